// File: rtl/dmem_dma_pkg.sv
// Shared types for the data-memory block-transfer engine: FSM states and command op codes.
package dmem_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OP_COPY = 1'b0,
    OP_FILL = 1'b1
  } op_t;

endpackage

// File: rtl/dmem_dma.sv
// Block-transfer initiator for the single-port data memory: forward COPY of a word range or
// FILL with a constant, with a running modular checksum of every word written.
module dmem_dma
  import dmem_dma_pkg::*;
#(
  parameter int addWidth  = 6,
  parameter int dataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 op,
  input  logic [addWidth-1:0]  src,
  input  logic [addWidth-1:0]  dst,
  input  logic [addWidth:0]    len,
  input  logic [dataWidth-1:0] fill_val,
  output logic                 busy,
  output logic                 done,
  output logic [dataWidth-1:0] checksum,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [addWidth-1:0]  mem_addr,
  output logic [dataWidth-1:0] mem_di,
  input  logic [dataWidth-1:0] mem_do
);

  state_t               r_state;
  op_t                  r_op;
  logic [addWidth-1:0]  r_src;
  logic [addWidth-1:0]  r_dst;
  logic [addWidth:0]    r_len;
  logic [dataWidth-1:0] r_fill;
  logic [dataWidth-1:0] r_buf;
  logic [addWidth:0]    r_idx;
  logic [dataWidth-1:0] r_sum;

  logic [addWidth:0]    w_idx_nxt;
  logic [addWidth-1:0]  w_off;
  logic [dataWidth-1:0] w_wdata;

  assign w_idx_nxt = r_idx + {{addWidth{1'b0}}, 1'b1};
  assign w_off     = r_idx[addWidth-1:0];
  assign w_wdata   = (r_op == OP_FILL) ? r_fill : r_buf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op    <= OP_COPY;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_fill  <= '0;
      r_buf   <= '0;
      r_idx   <= '0;
      r_sum   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_op   <= op_t'(op);
            r_src  <= src;
            r_dst  <= dst;
            r_len  <= len;
            r_fill <= fill_val;
            r_idx  <= '0;
            r_sum  <= '0;
            if (len == '0)
              r_state <= DONE;
            else if (op_t'(op) == OP_FILL)
              r_state <= WRITE;
            else
              r_state <= READ;
          end
        end
        READ: begin
          r_buf   <= mem_do;
          r_state <= WRITE;
        end
        WRITE: begin
          r_sum <= r_sum + w_wdata;
          r_idx <= w_idx_nxt;
          if (w_idx_nxt == r_len)
            r_state <= DONE;
          else if (r_op == OP_FILL)
            r_state <= WRITE;
          else
            r_state <= READ;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory port and status decode purely from registered state, so command inputs never reach the memory.
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_di   = '0;
    unique case (r_state)
      READ: begin
        mem_en   = 1'b1;
        mem_addr = r_src + w_off;
      end
      WRITE: begin
        mem_en   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = r_dst + w_off;
        mem_di   = w_wdata;
      end
      default: ;
    endcase
  end

  assign busy     = (r_state == READ) || (r_state == WRITE);
  assign done     = (r_state == DONE);
  assign checksum = r_sum;

endmodule

// File: tb/tb_dmem_dma.sv
// Bench for dmem_dma: a behavioural data memory, an expected-write scoreboard fed at command
// issue, and per-command checks of done timing, busy/enable cycle counts and checksum.
module tb_dmem_dma;
  import dmem_dma_pkg::*;

  localparam int AW    = 6;
  localparam int DW    = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          op;
  logic [AW-1:0] src;
  logic [AW-1:0] dst;
  logic [AW:0]   len;
  logic [DW-1:0] fill_val;
  logic          busy;
  logic          done;
  logic [DW-1:0] checksum;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_di;
  logic [DW-1:0] mem_do;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_checks = 0;
  int n_err    = 0;
  int n_en     = 0;

  dmem_dma #(.addWidth(AW), .dataWidth(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src(src), .dst(dst), .len(len),
    .fill_val(fill_val), .busy(busy), .done(done), .checksum(checksum),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  assign mem_do = mem[mem_addr];
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_di;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_en) n_en++;
    if (rst_n && mem_en && mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {26'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", {26'd0, mem_addr}, {26'd0, mon_e.a});
        chk("wr_data", {16'd0, mem_di}, {16'd0, mon_e.d});
      end
    end
  end

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk);
    #1 ld_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic run_cmd(input logic o, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic [AW:0] n, input logic [DW-1:0] fv, input int poke,
                         output int done_c);
    logic [DW-1:0] sum;
    logic [DW-1:0] w;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    int exp_done;
    int exp_en;
    int n_busy;
    sum = '0;
    for (int k = 0; k < int'(n); k++) begin
      ra = s + AW'(k);
      wa = d + AW'(k);
      w  = (o == OP_FILL) ? fv : ref_mem[ra];
      ref_mem[wa] = w;
      exp_q.push_back('{a: wa, d: w});
      sum = sum + w;
    end
    exp_done = (n == 0) ? 1 : ((o == OP_FILL) ? int'(n) + 1 : 2 * int'(n) + 1);
    exp_en   = (o == OP_FILL) ? int'(n) : 2 * int'(n);
    @(negedge clk);
    n_en = 0;
    start = 1'b1; op = o; src = s; dst = d; len = n; fill_val = fv;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; src = ~s; dst = ~d; len = '0; fill_val = ~fv;
    done_c = 0;
    n_busy = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == poke) begin
        start = 1'b1; op = ~o; src = s + 6'd5; dst = d + 6'd9; len = 7'd2; fill_val = 16'h1234;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        done_c = c;
        break;
      end
      if (busy) n_busy++;
    end
    start = 1'b0;
    chk("done_cycle", done_c, exp_done);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("busy_cycles", n_busy, exp_done - 1);
    chk("en_cycles", n_en, exp_en);
    chk("checksum", {16'd0, checksum}, {16'd0, sum});
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("checksum_hold", {16'd0, checksum}, {16'd0, sum});
    chk("queue_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc;
    rst_n = 1'b0; start = 1'b0; op = 1'b0; src = '0; dst = '0; len = '0; fill_val = '0;
    for (int i = 0; i < DEPTH; i++) load(AW'(i), DW'(i * 37 + 11));
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_checksum", {16'd0, checksum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FILL wrapping past the top address
    run_cmd(OP_FILL, 6'h00, 6'h3E, 7'd4, 16'hA5A5, 0, dc);
    chk("fill_done_c", dc, 5);
    chk("fill_sum_c", {16'd0, checksum}, 32'h9694);
    chk("fill_m3e", {16'd0, mem[6'h3E]}, 32'hA5A5);
    chk("fill_m3f", {16'd0, mem[6'h3F]}, 32'hA5A5);
    chk("fill_m00", {16'd0, mem[6'h00]}, 32'hA5A5);
    chk("fill_m01", {16'd0, mem[6'h01]}, 32'hA5A5);
    chk("fill_m02", {16'd0, mem[6'h02]}, {16'd0, ref_mem[6'h02]});

    // plain COPY
    load(6'h10, 16'd1); load(6'h11, 16'd2); load(6'h12, 16'd3);
    run_cmd(OP_COPY, 6'h10, 6'h20, 7'd3, 16'h0, 0, dc);
    chk("copy_done_c", dc, 7);
    chk("copy_sum_c", {16'd0, checksum}, 32'd6);
    for (int k = 0; k < 3; k++) begin
      chk("copy_dst", {16'd0, mem[6'h20 + k]}, k + 1);
      chk("copy_src", {16'd0, mem[6'h10 + k]}, k + 1);
    end

    // zero length
    run_cmd(OP_COPY, 6'h05, 6'h06, 7'd0, 16'h0, 0, dc);
    chk("len0_done_c", dc, 1);
    chk("len0_sum", {16'd0, checksum}, 32'd0);

    // start pulsed mid-COPY is ignored
    run_cmd(OP_COPY, 6'h10, 6'h28, 7'd4, 16'h0, 3, dc);
    chk("poke_done_c", dc, 9);

    // full-depth FILL
    run_cmd(OP_FILL, 6'h07, 6'h07, 7'd64, 16'h0101, 0, dc);
    chk("full_sum_c", {16'd0, checksum}, 32'h4040);

    // reset during cycle 3 of an 8-word COPY
    for (int i = 0; i < 8; i++) load(AW'(6'h30 + i), DW'(16'h0500 + i));
    for (int i = 0; i < 8; i++) load(AW'(6'h08 + i), DW'(16'h0900 + i));
    exp_q.push_back('{a: 6'h08, d: 16'h0500});
    ref_mem[6'h08] = 16'h0500;
    @(negedge clk);
    start = 1'b1; op = OP_COPY; src = 6'h30; dst = 6'h08; len = 7'd8;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_en", {31'd0, mem_en}, 32'd0);
    chk("arst_we", {31'd0, mem_we}, 32'd0);
    chk("arst_addr", {26'd0, mem_addr}, 32'd0);
    chk("arst_di", {16'd0, mem_di}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum", {16'd0, checksum}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_q_empty", exp_q.size(), 32'd0);
    chk("arst_w0", {16'd0, mem[6'h08]}, 32'h0500);
    for (int i = 1; i < 8; i++) chk("arst_unwritten", {16'd0, mem[6'h08 + i]}, 32'h0900 + i);
    run_cmd(OP_FILL, 6'h00, 6'h0C, 7'd3, 16'h0F0F, 0, dc);
    chk("post_rst_done_c", dc, 4);
    chk("post_rst_m0e", {16'd0, mem[6'h0E]}, 32'h0F0F);

    // overlapping forward COPY
    load(6'h00, 16'h000A); load(6'h01, 16'h000B); load(6'h02, 16'h000C); load(6'h03, 16'h000D);
    run_cmd(OP_COPY, 6'h00, 6'h01, 7'd3, 16'h0, 0, dc);
    for (int i = 0; i < 4; i++) chk("overlap", {16'd0, mem[i]}, 32'h000A);
    chk("overlap_sum", {16'd0, checksum}, 32'h001E);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
